// File: rtl/ext_bus_pkg.sv
// Shared encodings for EXT_* bus responders: transfer sizes, responder FSM
// states and the wait-state counter type.
package ext_bus_pkg;

  localparam int WAIT_CNT_W = 4;

  localparam logic [2:0] SZ_BYTE = 3'd0;
  localparam logic [2:0] SZ_HALF = 3'd1;
  localparam logic [2:0] SZ_WORD = 3'd2;

  // The completion cycle (EXT_HREADYOUT=1) is the DONE slot: it can be the
  // ACCESS, RDWAIT or last WAIT cycle, and it accepts a back-to-back request.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RDWAIT,
    ST_WAIT
  } state_t;

  typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

  function automatic logic size_is_legal(input logic [2:0] size);
    return (size == SZ_BYTE) || (size == SZ_HALF) || (size == SZ_WORD);
  endfunction

endpackage

// File: rtl/ext_be_decode.sv
// Byte-enable decode for a little-endian 32-bit word: {size, offset} -> be,
// plus a flag for illegal sizes and misaligned half/word accesses.
module ext_be_decode
  import ext_bus_pkg::*;
(
  input  logic [2:0] i_size,
  input  logic [1:0] i_offset,
  output logic [3:0] o_be,
  output logic       o_misaligned
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    o_be         = 4'b0000;
    o_misaligned = 1'b0;
    case (i_size)
      SZ_BYTE: o_be = 4'b0001 << i_offset;
      SZ_HALF: begin
        if (i_offset == 2'd0)      o_be = 4'b0011;
        else if (i_offset == 2'd2) o_be = 4'b1100;
        else                       o_misaligned = 1'b1;
      end
      SZ_WORD: begin
        if (i_offset == 2'd0) o_be = 4'b1111;
        else                  o_misaligned = 1'b1;
      end
      default: o_misaligned = !size_is_legal(i_size);
    endcase
  end

endmodule

// File: rtl/ext_bus_responder.sv
// Responder for the CPU EXT_* bus: captures the address phase, drives a
// one-cycle local register strobe, inserts wait states and returns read data.
module ext_bus_responder
  import ext_bus_pkg::*;
#(
  parameter int AWIDTH      = 16,
  parameter int REG_WORDS   = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EXT_HSEL,
  input  logic [AWIDTH-1:0] EXT_HADDR,
  input  logic              EXT_HWRITE,
  input  logic [2:0]        EXT_HSIZE,
  input  logic [31:0]       EXT_HWDATA,
  output logic [31:0]       EXT_HRDATA,
  output logic              EXT_HREADYOUT,
  output logic [3:0]        reg_addr,
  output logic              reg_en,
  output logic              reg_we,
  output logic [3:0]        reg_be,
  output logic [31:0]       reg_wdata,
  input  logic [31:0]       reg_rdata,
  output logic              err_flag,
  output logic [7:0]        err_count
);

  localparam bit        WS_ZERO = (WAIT_STATES == 0);
  localparam bit        WS_ONE  = (WAIT_STATES == 1);
  localparam wait_cnt_t WS_M1   = WAIT_CNT_W'(WAIT_STATES - 1);

  state_t      r_state;
  logic        r_write;
  logic        r_illegal;
  wait_cnt_t   r_wait_cnt;
  logic        r_hreadyout;
  logic [31:0] r_hrdata;
  logic        r_reg_en;
  logic        r_reg_we;
  logic [3:0]  r_reg_be;
  logic [3:0]  r_reg_addr;
  logic        r_err_flag;
  logic [7:0]  r_err_count;

  logic [3:0]        w_be;
  logic              w_misaligned;
  logic [AWIDTH-3:0] w_word_idx;
  logic              w_out_of_range;
  logic              w_illegal;
  logic              w_accept;

  ext_be_decode u_be_decode (
    .i_size      (EXT_HSIZE),
    .i_offset    (EXT_HADDR[1:0]),
    .o_be        (w_be),
    .o_misaligned(w_misaligned)
  );

  assign w_word_idx     = EXT_HADDR[AWIDTH-1:2];
  assign w_out_of_range = (32'(w_word_idx) >= 32'(REG_WORDS));
  assign w_illegal      = w_misaligned || w_out_of_range;
  assign w_accept       = EXT_HSEL && ((r_state == ST_IDLE) || r_hreadyout);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_write     <= 1'b0;
      r_illegal   <= 1'b0;
      r_wait_cnt  <= '0;
      r_hreadyout <= 1'b0;
      r_hrdata    <= '0;
      r_reg_en    <= 1'b0;
      r_reg_we    <= 1'b0;
      r_reg_be    <= '0;
      r_reg_addr  <= '0;
      r_err_flag  <= 1'b0;
      r_err_count <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
      r_reg_en <= 1'b0;
      r_reg_we <= 1'b0;
      r_reg_be <= '0;

      // Local read data is valid in the RDWAIT cycle only.
      if (r_state == ST_RDWAIT) r_hrdata <= reg_rdata;

      if (w_accept) begin
        r_state     <= ST_ACCESS;
        r_write     <= EXT_HWRITE;
        r_illegal   <= w_illegal;
        r_reg_en    <= !w_illegal;
        r_reg_we    <= EXT_HWRITE && !w_illegal;
        r_reg_be    <= w_illegal ? 4'b0000 : w_be;
        r_reg_addr  <= EXT_HADDR[5:2];
        r_hreadyout <= WS_ZERO && (EXT_HWRITE || w_illegal);
        if (w_illegal) begin
          r_hrdata   <= '0;
          r_err_flag <= 1'b1;
          if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
        end
      end else if (r_hreadyout) begin
        r_state     <= ST_IDLE;
        r_hreadyout <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: ;
          ST_ACCESS: begin
            if (!r_write && !r_illegal) begin
              r_state     <= ST_RDWAIT;
              r_hreadyout <= WS_ZERO;
            end else begin
              r_state     <= ST_WAIT;
              r_wait_cnt  <= WS_M1;
              r_hreadyout <= WS_ONE;
            end
          end
          ST_RDWAIT: begin
            r_state     <= ST_WAIT;
            r_wait_cnt  <= WS_M1;
            r_hreadyout <= WS_ONE;
          end
          ST_WAIT: begin
            r_wait_cnt  <= r_wait_cnt - 1'b1;
            r_hreadyout <= (r_wait_cnt == wait_cnt_t'(1));
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // With no wait states the read completes in RDWAIT, before the hold register loads.
  assign EXT_HRDATA    = ((r_state == ST_RDWAIT) && r_hreadyout) ? reg_rdata : r_hrdata;
  assign EXT_HREADYOUT = r_hreadyout;
  assign reg_addr      = r_reg_addr;
  assign reg_en        = r_reg_en;
  assign reg_we        = r_reg_we;
  assign reg_be        = r_reg_be;
  assign reg_wdata     = EXT_HWDATA;
  assign err_flag      = r_err_flag;
  assign err_count     = r_err_count;

endmodule

// File: tb/tb_ext_bus_responder.sv
// Bench for ext_bus_responder: two instances (0 and 3 wait states), each with a
// local register-file stand-in, checked against a transfer-level memory model.
module tb_ext_bus_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        hsel[2];
  logic [15:0] haddr[2];
  logic        hwrite[2];
  logic [2:0]  hsize[2];
  logic [31:0] hwdata[2];
  logic [31:0] hrdata[2];
  logic        hready[2];
  logic [3:0]  reg_addr[2];
  logic        reg_en[2];
  logic        reg_we[2];
  logic [3:0]  reg_be[2];
  logic [31:0] reg_wdata[2];
  logic [31:0] reg_rdata[2];
  logic        err_flag[2];
  logic [7:0]  err_count[2];

  bit [31:0] pmem[2][16];
  bit [31:0] mdl[2][16];
  int        merr[2];
  bit        mflag[2];

  int n_total = 0;
  int n_bad   = 0;

  ext_bus_responder #(.AWIDTH(16), .REG_WORDS(16), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .EXT_HSEL(hsel[0]), .EXT_HADDR(haddr[0]), .EXT_HWRITE(hwrite[0]),
    .EXT_HSIZE(hsize[0]), .EXT_HWDATA(hwdata[0]), .EXT_HRDATA(hrdata[0]),
    .EXT_HREADYOUT(hready[0]), .reg_addr(reg_addr[0]), .reg_en(reg_en[0]),
    .reg_we(reg_we[0]), .reg_be(reg_be[0]), .reg_wdata(reg_wdata[0]),
    .reg_rdata(reg_rdata[0]), .err_flag(err_flag[0]), .err_count(err_count[0])
  );

  ext_bus_responder #(.AWIDTH(16), .REG_WORDS(16), .WAIT_STATES(3)) u_dut1 (
    .clk(clk), .rst(rst),
    .EXT_HSEL(hsel[1]), .EXT_HADDR(haddr[1]), .EXT_HWRITE(hwrite[1]),
    .EXT_HSIZE(hsize[1]), .EXT_HWDATA(hwdata[1]), .EXT_HRDATA(hrdata[1]),
    .EXT_HREADYOUT(hready[1]), .reg_addr(reg_addr[1]), .reg_en(reg_en[1]),
    .reg_we(reg_we[1]), .reg_be(reg_be[1]), .reg_wdata(reg_wdata[1]),
    .reg_rdata(reg_rdata[1]), .err_flag(err_flag[1]), .err_count(err_count[1])
  );

  // Local register file: read data valid only in the cycle after a read strobe.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reg_en[d] && reg_we[d])
        for (int b = 0; b < 4; b++)
          if (reg_be[d][b]) pmem[d][reg_addr[d]][8*b +: 8] <= reg_wdata[d][8*b +: 8];
      reg_rdata[d] <= (reg_en[d] && !reg_we[d]) ? pmem[d][reg_addr[d]] : $urandom;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Called at a negedge where the responder can accept; returns at the
  // completion negedge when chain=1, else one cycle later.
  task automatic do_xfer(input int d, input bit wr, input logic [15:0] a,
                         input logic [2:0] sz, input logic [31:0] wd, input bit chain);
    bit         legal;
    logic [3:0] ebe;
    int         widx, nb, lat, c;
    bit         extra_en;
    widx  = int'(a[15:2]);
    legal = (sz <= 3'd2) && !(sz == 3'd1 && a[0]) && !(sz == 3'd2 && a[1:0] != 2'd0)
            && (widx < 16);
    ebe   = 4'b0000;
    if (legal) begin
      nb  = 1 << sz;
      ebe = 4'(((1 << nb) - 1) << a[1:0]);
    end
    lat = (wr || !legal) ? 1 + ws_of(d) : 2 + ws_of(d);

    hsel[d] = 1'b1; haddr[d] = a; hwrite[d] = wr; hsize[d] = sz;
    @(negedge clk);
    hsel[d] = 1'b0; hwdata[d] = wd;
    check("reg_en", 32'(reg_en[d]), 32'(legal));
    check("reg_be", 32'(reg_be[d]), 32'(ebe));
    if (legal) begin
      check("reg_we", 32'(reg_we[d]), 32'(wr));
      check("reg_addr", 32'(reg_addr[d]), 32'(a[5:2]));
    end

    c = 1; extra_en = 1'b0;
    while (!hready[d] && c < 40) begin
      hsel[d]   = 1'($urandom_range(0, 1));
      haddr[d]  = 16'($urandom_range(0, 'h4f));
      hwrite[d] = 1'($urandom_range(0, 1));
      hsize[d]  = 3'($urandom_range(0, 2));
      @(negedge clk);
      c++;
      if (reg_en[d]) extra_en = 1'b1;
    end
    hsel[d] = 1'b0;
    check("latency", 32'(c), 32'(lat));
    check("extra_reg_en", 32'(extra_en), 32'd0);

    if (legal && wr)
      for (int b = 0; b < 4; b++)
        if (ebe[b]) mdl[d][widx][8*b +: 8] = wd[8*b +: 8];
    if (!legal) begin
      mflag[d] = 1'b1;
      if (merr[d] < 255) merr[d]++;
      check("hrdata_illegal", hrdata[d], 32'd0);
    end else if (!wr) begin
      check("hrdata", hrdata[d], mdl[d][widx]);
    end
    check("err_flag", 32'(err_flag[d]), 32'(mflag[d]));
    check("err_count", 32'(err_count[d]), 32'(merr[d]));

    if (!chain) begin
      @(negedge clk);
      check("hready_one_cycle", 32'(hready[d]), 32'd0);
    end
  endtask

  task automatic run_random(input int d, input int n);
    logic [2:0]  sz;
    logic [15:0] a;
    int          r;
    bit          chain;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      sz = 3'd0;
      else if (r < 6) sz = 3'd1;
      else if (r < 9) sz = 3'd2;
      else            sz = 3'($urandom_range(3, 7));
      a     = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 'h47));
      chain = (i != n - 1) && ($urandom_range(0, 2) == 0);
      do_xfer(d, 1'($urandom_range(0, 1)), a, sz, $urandom, chain);
      if (!chain)
        repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic check_reset_values(input int d);
    check("rst_hready", 32'(hready[d]), 32'd0);
    check("rst_hrdata", hrdata[d], 32'd0);
    check("rst_reg_en", 32'(reg_en[d]), 32'd0);
    check("rst_reg_we", 32'(reg_we[d]), 32'd0);
    check("rst_reg_be", 32'(reg_be[d]), 32'd0);
    check("rst_reg_addr", 32'(reg_addr[d]), 32'd0);
    check("rst_err_flag", 32'(err_flag[d]), 32'd0);
    check("rst_err_count", 32'(err_count[d]), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      hsel[d] = 1'b0; haddr[d] = '0; hwrite[d] = 1'b0; hsize[d] = '0; hwdata[d] = '0;
      merr[d] = 0; mflag[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) check_reset_values(d);
    rst = 1'b0;

    // No wait states: directed cases.
    do_xfer(0, 1'b1, 16'h0008, 3'd2, 32'hDEADBEEF, 1'b0);
    do_xfer(0, 1'b0, 16'h0008, 3'd2, 32'h0, 1'b0);
    do_xfer(0, 1'b1, 16'h0008, 3'd2, 32'h12345678, 1'b0);
    do_xfer(0, 1'b0, 16'h0008, 3'd2, 32'h0, 1'b0);
    do_xfer(0, 1'b1, 16'h0003, 3'd0, 32'hA5A5A5A5, 1'b0);
    do_xfer(0, 1'b1, 16'h0002, 3'd1, 32'h5A5A5A5A, 1'b0);
    do_xfer(0, 1'b1, 16'h0001, 3'd1, 32'hFFFFFFFF, 1'b0);
    do_xfer(0, 1'b0, 16'h0040, 3'd2, 32'h0, 1'b0);
    do_xfer(0, 1'b0, 16'h0000, 3'd2, 32'h0, 1'b1);
    do_xfer(0, 1'b0, 16'h0003, 3'd0, 32'h0, 1'b0);

    // Three wait states: back-to-back write then read.
    do_xfer(1, 1'b1, 16'h0008, 3'd2, 32'hCAFEF00D, 1'b1);
    do_xfer(1, 1'b0, 16'h0008, 3'd2, 32'h0, 1'b0);
    do_xfer(1, 1'b0, 16'h0044, 3'd2, 32'h0, 1'b0);

    run_random(0, 150);
    run_random(1, 150);

    // Reset lands in the address-phase cycle of a read.
    hsel[0] = 1'b1; haddr[0] = 16'h0008; hwrite[0] = 1'b0; hsize[0] = 3'd2;
    hsel[1] = 1'b1; haddr[1] = 16'h0008; hwrite[1] = 1'b0; hsize[1] = 3'd2;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; hsel[0] = 1'b0; hsel[1] = 1'b0;
    for (int d = 0; d < 2; d++) check_reset_values(d);
    repeat (6) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check("abort_reg_en", 32'(reg_en[d]), 32'd0);
        check("abort_hready", 32'(hready[d]), 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
